// File: rtl/comp_mac_pkg.sv
// comp_mac_pkg: shared definitions for the comp_mac multiply/accumulate engine.
//   state_t  - burst FSM encodings (ST_IDLE / ST_ACC)
//   MODE_*   - i_mode encodings
//   ctl_t    - per-beat control word carried down the pipeline next to the data
//   acc_width() - default accumulator width for a given operand width
package comp_mac_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // valid: a beat occupies this stage
    // first: beat opens a burst (accumulator restarts from its product)
    // emit : beat closes a burst (result goes to the output register)
    typedef struct packed {
        logic valid;
        logic first;
        logic emit;
    } ctl_t;

    // Full product plus four guard bits, so short bursts never wrap.
    function automatic int acc_width(input int size);
        return 2 * size + 4;
    endfunction

endpackage

// File: rtl/comp_mac_if.sv
// comp_mac_if: stream bundle for comp_mac.
//   Operand side : i_valid, o_ready, i_param, i_param_2, i_mode, i_last
//   Result side  : o_param, o_ovf, dv, i_ready
//   master: producer/consumer (testbench or surrounding datapath)
//   slave : the comp_mac engine
interface comp_mac_if #(
    parameter int p_size  = 8,
    parameter int p_lanes = 2,
    parameter int p_acc_w = 2 * p_size + 4
);
    logic                       i_valid;
    logic                       o_ready;
    logic [p_lanes*p_size-1:0]  i_param;
    logic [p_lanes*p_size-1:0]  i_param_2;
    logic                       i_mode;
    logic                       i_last;
    logic [p_lanes*p_acc_w-1:0] o_param;
    logic [p_lanes-1:0]         o_ovf;
    logic                       dv;
    logic                       i_ready;

    modport master (
        output i_valid, i_param, i_param_2, i_mode, i_last, i_ready,
        input  o_ready, o_param, o_ovf, dv
    );

    modport slave (
        input  i_valid, i_param, i_param_2, i_mode, i_last, i_ready,
        output o_ready, o_param, o_ovf, dv
    );
endinterface

// File: rtl/comp_mac_lane.sv
// comp_mac_lane: one datapath lane of comp_mac.
//   Multiplier pipeline (p_lat-1 product registers) followed by the final stage
//   holding the running accumulator, the sticky overflow flag and the result
//   register. Control (fin_*) arrives already aligned with prod_fin.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   adv                 pipeline advance (0 = hold everything)
//   a, b                lane operands of the beat being accepted
//   fin_valid/first/emit control word of the beat in the final stage
//   result, ovf         registered lane result and its overflow flag
// Optional: COMP_MAC_SATURATE_EN clamps the accumulator to all-ones after overflow.
module comp_mac_lane
    import comp_mac_pkg::*;
#(
    parameter int p_size  = 8,
    parameter int p_acc_w = acc_width(p_size),
    parameter int p_lat   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic [p_size-1:0]  a,
    input  logic [p_size-1:0]  b,
    input  logic               fin_valid,
    input  logic               fin_first,
    input  logic               fin_emit,
    output logic [p_acc_w-1:0] result,
    output logic               ovf
);
    logic [2*p_size-1:0] prod_in;
    logic [2*p_size-1:0] prod_fin;

    assign prod_in = (2*p_size)'(a) * (2*p_size)'(b);

    generate
        if (p_lat > 1) begin : g_pipe
            logic [2*p_size-1:0] prod_pipe [p_lat-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < p_lat - 1; i++) prod_pipe[i] <= '0;
                end else if (adv) begin
                    prod_pipe[0] <= prod_in;
                    for (int i = 1; i < p_lat - 1; i++) prod_pipe[i] <= prod_pipe[i-1];
                end
            end

            assign prod_fin = prod_pipe[p_lat-2];
        end else begin : g_nopipe
            assign prod_fin = prod_in;
        end
    endgenerate

    logic [p_acc_w-1:0] acc_reg, acc_next, base;
    logic [p_acc_w:0]   sum;
    logic               ovf_reg, ovf_next;
    logic [p_acc_w-1:0] result_reg;
    logic               ovf_out_reg;

    always_comb begin
        // A burst-opening beat ignores whatever the accumulator holds.
        base     = fin_first ? '0 : acc_reg;
        sum      = {1'b0, base} + (p_acc_w+1)'(prod_fin);
        ovf_next = (~fin_first & ovf_reg) | sum[p_acc_w];
`ifdef COMP_MAC_SATURATE_EN
        // Sticky flag keeps the lane pinned at all-ones until the burst closes.
        acc_next = ovf_next ? '1 : sum[p_acc_w-1:0];
`else
        acc_next = sum[p_acc_w-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            result_reg  <= '0;
            ovf_out_reg <= 1'b0;
        end else if (adv && fin_valid) begin
            if (fin_emit) begin
                result_reg  <= acc_next;
                ovf_out_reg <= ovf_next;
                acc_reg     <= '0;
                ovf_reg     <= 1'b0;
            end else begin
                acc_reg <= acc_next;
                ovf_reg <= ovf_next;
            end
        end
    end

    assign result = result_reg;
    assign ovf    = ovf_out_reg;

endmodule

// File: rtl/comp_mac.sv
// comp_mac: multi-lane pipelined unsigned multiply / multiply-accumulate engine.
//   One operand stream in (valid/ready), one result stream out (dv/i_ready).
//   The burst FSM, handshake and stall logic live here; arithmetic is in
//   comp_mac_lane, instantiated p_lanes times.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   ena  global enable, 0 freezes all state
//   bus  comp_mac_if.slave (operands, mode/last, results, overflow, handshakes)
// Optional: COMP_MAC_SATURATE_EN (see comp_mac_lane) selects saturating accumulation.
module comp_mac
    import comp_mac_pkg::*;
#(
    parameter int p_size  = 8,
    parameter int p_lanes = 2,
    parameter int p_acc_w = acc_width(p_size),
    parameter int p_lat   = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ena,
    comp_mac_if.slave bus
);
    state_t state_reg, state_next;
    ctl_t   ctl_in, ctl_fin;
    logic   stall, adv, accept;
    logic   dv_reg;

    logic [p_lanes*p_acc_w-1:0] result_all;
    logic [p_lanes-1:0]         ovf_all;

    // A presented but unconsumed result freezes the whole pipeline.
    assign stall       = dv_reg & ~bus.i_ready;
    assign adv         = ena & ~stall;
    assign bus.o_ready = adv & ~rst;
    assign accept      = bus.i_valid & bus.o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        ctl_in       = '0;
        ctl_in.valid = accept;
        if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    ctl_in.first = 1'b1;
                    if (bus.i_mode == MODE_ACC && !bus.i_last) state_next = ST_ACC;
                    else                                       ctl_in.emit = 1'b1;
                end
                ST_ACC: begin
                    // Mode is ignored mid-burst; only i_last closes it.
                    if (bus.i_last) begin
                        ctl_in.emit = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Control word travels alongside the product registers in the lanes.
    generate
        if (p_lat > 1) begin : g_ctl
            ctl_t ctl_pipe [p_lat-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < p_lat - 1; i++) ctl_pipe[i] <= '0;
                end else if (adv) begin
                    ctl_pipe[0] <= ctl_in;
                    for (int i = 1; i < p_lat - 1; i++) ctl_pipe[i] <= ctl_pipe[i-1];
                end
            end

            assign ctl_fin = ctl_pipe[p_lat-2];
        end else begin : g_ctl_comb
            assign ctl_fin = ctl_in;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      dv_reg <= 1'b0;
        else if (adv) dv_reg <= ctl_fin.valid & ctl_fin.emit;
    end

    for (genvar gi = 0; gi < p_lanes; gi++) begin : g_lane
        comp_mac_lane #(
            .p_size  (p_size),
            .p_acc_w (p_acc_w),
            .p_lat   (p_lat)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .a         (bus.i_param[gi*p_size +: p_size]),
            .b         (bus.i_param_2[gi*p_size +: p_size]),
            .fin_valid (ctl_fin.valid),
            .fin_first (ctl_fin.first),
            .fin_emit  (ctl_fin.emit),
            .result    (result_all[gi*p_acc_w +: p_acc_w]),
            .ovf       (ovf_all[gi])
        );
    end

    assign bus.o_param = result_all;
    assign bus.o_ovf   = ovf_all;
    assign bus.dv      = dv_reg;

endmodule

// File: tb/tb_comp_mac.sv
// tb_comp_mac: directed self-checking bench for comp_mac
// (p_size=4, p_lanes=2, p_acc_w=12, p_lat=2). Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_comp_mac;
    localparam int P_SIZE  = 4;
    localparam int P_LANES = 2;
    localparam int P_ACC_W = 12;
    localparam int P_LAT   = 2;

`ifdef COMP_MAC_SATURATE_EN
    localparam logic [63:0] OVF_EXP = 64'd4095;
`else
    localparam logic [63:0] OVF_EXP = 64'd404;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ena;
    int   checks = 0;
    int   errors = 0;

    comp_mac_if #(.p_size(P_SIZE), .p_lanes(P_LANES), .p_acc_w(P_ACC_W)) bus ();

    comp_mac #(
        .p_size  (P_SIZE),
        .p_lanes (P_LANES),
        .p_acc_w (P_ACC_W),
        .p_lat   (P_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Backpressure stimulus and hand-computed products
    int bp_a0 [6] = '{1, 2, 3, 4, 5, 6};
    int bp_b0 [6] = '{2, 3, 4, 5, 6, 7};
    int bp_a1 [6] = '{15, 14, 13, 12, 11, 10};
    int bp_b1 [6] = '{0, 1, 2, 3, 4, 5};
    int bp_e0 [6] = '{2, 6, 12, 20, 30, 42};
    int bp_e1 [6] = '{0, 14, 26, 36, 44, 50};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one beat, expect it to be taken at the next rising edge.
    task automatic issue(input int a0, input int b0, input int a1, input int b1,
                         input logic mode, input logic last);
        bus.i_param   = {4'(a1), 4'(a0)};
        bus.i_param_2 = {4'(b1), 4'(b0)};
        bus.i_mode    = mode;
        bus.i_last    = last;
        bus.i_valid   = 1'b1;
        #1;
        $display("beat l0=%0d*%0d l1=%0d*%0d mode=%0d last=%0d", a0, b0, a1, b1, mode, last);
        check_val("issue_rdy", bus.o_ready, 1);
        step();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        int dv_seen;
        rst           = 1'b1;
        ena           = 1'b1;
        bus.i_valid   = 1'b1;
        bus.i_ready   = 1'b1;
        bus.i_param   = '0;
        bus.i_param_2 = '0;
        bus.i_mode    = 1'b0;
        bus.i_last    = 1'b0;

        // Reset held 3 cycles with i_valid asserted
        repeat (3) begin
            @(negedge clk);
            check_val("rst_dv", bus.dv, 0);
            check_val("rst_param", bus.o_param, 0);
            check_val("rst_rdy", bus.o_ready, 0);
        end
        bus.i_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_val("rel_rdy", bus.o_ready, 1);

        // Plain multiply, latency 2
        issue(15, 15, 3, 4, 1'b0, 1'b0);
        check_val("mul_t1_dv", bus.dv, 0);
        step();
        check_val("mul_dv", bus.dv, 1);
        check_val("mul_l0", bus.o_param[11:0], 225);
        check_val("mul_l1", bus.o_param[23:12], 12);
        check_val("mul_ovf", bus.o_ovf, 0);
        $display("result l0=%0d l1=%0d ovf=%b", bus.o_param[11:0], bus.o_param[23:12], bus.o_ovf);
        step();
        check_val("mul_drop", bus.dv, 0);

        // Three-beat accumulate burst
        issue(2, 3, 1, 1, 1'b1, 1'b0);
        check_val("acc_b1_dv", bus.dv, 0);
        issue(4, 5, 1, 1, 1'b1, 1'b0);
        check_val("acc_b2_dv", bus.dv, 0);
        issue(1, 1, 1, 1, 1'b1, 1'b1);
        check_val("acc_b3_dv", bus.dv, 0);
        step();
        check_val("acc_dv", bus.dv, 1);
        check_val("acc_l0", bus.o_param[11:0], 27);
        check_val("acc_l1", bus.o_param[23:12], 3);
        check_val("acc_ovf", bus.o_ovf, 0);
        $display("result l0=%0d l1=%0d ovf=%b", bus.o_param[11:0], bus.o_param[23:12], bus.o_ovf);
        step();
        check_val("acc_once", bus.dv, 0);

        // 20 x 225 overflows 12 bits; mode toggled mid-burst must be ignored
        dv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            issue(15, 15, 0, 0, (k == 0) || (k % 3 == 1), k == 19);
            if (bus.dv) dv_seen++;
        end
        check_val("ovf_nodv", dv_seen, 0);
        step();
        check_val("ovf_dv", bus.dv, 1);
        check_val("ovf_l0", bus.o_param[11:0], OVF_EXP);
        check_val("ovf_l1", bus.o_param[23:12], 0);
        check_val("ovf_flag", bus.o_ovf, 2'b01);
        $display("result l0=%0d l1=%0d ovf=%b", bus.o_param[11:0], bus.o_param[23:12], bus.o_ovf);
        issue(1, 1, 0, 0, 1'b0, 1'b0);
        step();
        check_val("ovf_clr_l0", bus.o_param[11:0], 1);
        check_val("ovf_clr", bus.o_ovf, 0);

        // Enable low freezes an in-flight beat
        issue(3, 5, 2, 2, 1'b0, 1'b0);
        ena = 1'b0;
        #1;
        check_val("frz_rdy", bus.o_ready, 0);
        repeat (3) begin
            step();
            check_val("frz_dv", bus.dv, 0);
        end
        ena = 1'b1;
        step();
        check_val("frz_out_dv", bus.dv, 1);
        check_val("frz_l0", bus.o_param[11:0], 15);
        check_val("frz_l1", bus.o_param[23:12], 4);
        $display("result l0=%0d l1=%0d ovf=%b", bus.o_param[11:0], bus.o_param[23:12], bus.o_ovf);
        step();

        // Backpressure: producer and consumer run concurrently
        fork
            begin : producer
                int idx = 0;
                @(negedge clk);
                #2;
                for (int g = 0; g < 60 && idx < 6; g++) begin
                    bus.i_param   = {4'(bp_a1[idx]), 4'(bp_a0[idx])};
                    bus.i_param_2 = {4'(bp_b1[idx]), 4'(bp_b0[idx])};
                    bus.i_mode    = 1'b0;
                    bus.i_last    = 1'b0;
                    bus.i_valid   = 1'b1;
                    if (bus.o_ready) begin
                        $display("beat bp idx=%0d", idx);
                        idx++;
                    end
                    @(negedge clk);
                    #2;
                end
                bus.i_valid = 1'b0;
                check_val("bp_sent", idx, 6);
            end
            begin : consumer
                int got = 0;
                logic held_stall = 1'b0;
                logic [23:0] held_param = '0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    bus.i_ready = !((c >= 3 && c <= 5) || c == 9);
                    #1;
                    if (held_stall) begin
                        check_val("bp_hold_dv", bus.dv, 1);
                        check_val("bp_hold", bus.o_param, held_param);
                    end
                    if (bus.dv && !bus.i_ready) begin
                        check_val("bp_rdy", bus.o_ready, 0);
                        held_param = bus.o_param;
                        held_stall = 1'b1;
                    end else begin
                        held_stall = 1'b0;
                    end
                    if (bus.dv && bus.i_ready) begin
                        $display("result bp %0d l0=%0d l1=%0d", got, bus.o_param[11:0], bus.o_param[23:12]);
                        if (got < 6) begin
                            check_val("bp_l0", bus.o_param[11:0], 64'(bp_e0[got]));
                            check_val("bp_l1", bus.o_param[23:12], 64'(bp_e1[got]));
                        end
                        got++;
                    end
                end
                check_val("bp_count", got, 6);
                bus.i_ready = 1'b1;
            end
        join
        @(negedge clk);

        // Reset in the middle of an accumulate burst
        issue(5, 5, 0, 0, 1'b1, 1'b0);
        issue(5, 5, 0, 0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_val("mrst_dv", bus.dv, 0);
        check_val("mrst_rdy", bus.o_ready, 0);
        step();
        check_val("mrst_dv2", bus.dv, 0);
        rst = 1'b0;
        issue(1, 1, 0, 0, 1'b1, 1'b1);
        step();
        check_val("mrst_out_dv", bus.dv, 1);
        check_val("mrst_l0", bus.o_param[11:0], 1);
        check_val("mrst_ovf", bus.o_ovf, 0);
        $display("result l0=%0d l1=%0d ovf=%b", bus.o_param[11:0], bus.o_param[23:12], bus.o_ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_mac.md
Name: comp_mac

Overview:
- Parametrised, multi-lane, pipelined unsigned multiply / multiply-accumulate engine.
- Successor to the single-lane p_size multiplier component.
- Adds lane count, configurable pipeline depth, accumulate bursts, valid/ready backpressure and an overflow flag.
- Sits between operand producers and result consumers in the datapath; one stream in, one stream out.

Parameters:
- p_size, 8, operand width per lane (bits)
- p_lanes, 2, number of independent parallel lanes
- p_acc_w, 2*p_size+4, accumulator/result width per lane (must be >= 2*p_size)
- p_lat, 2, multiply pipeline stages from accepted beat to result (>= 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  global enable; 0 freezes all state
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_param  in  p_lanes*p_size  operand A, lane k at [k*p_size +: p_size]
- i_param_2  in  p_lanes*p_size  operand B, same packing
- i_mode  in  1  0 = multiply, 1 = accumulate
- i_last  in  1  closes an accumulate burst (ignored when mode=0)
- o_param  out  p_lanes*p_acc_w  per-lane result, lane k at [k*p_acc_w +: p_acc_w]
- o_ovf  out  p_lanes  per-lane overflow seen in the reported result
- dv  out  1  result valid
- i_ready  in  1  downstream accepts result

Behaviour:
- Reset: dv=0, o_param=0, o_ovf=0, o_ready=0 while rst=1. Accumulators, pipeline valids and FSM are cleared. Reset is asynchronous; mid-operation reset discards any open burst and in-flight beats.
- Stall condition: stall = dv & ~i_ready.
- o_ready = ena & ~stall & ~rst. A beat is accepted when i_valid & o_ready.
- Stall/freeze: while stall or ena=0, the whole pipeline holds. o_param, o_ovf and dv stay stable. No beat is lost or duplicated.
- Arithmetic: unsigned. Product is 2*p_size bits, zero-extended to p_acc_w.
- FSM (shared by all lanes), states IDLE and ACC:
  - IDLE, accepted beat, mode=0 -> stay IDLE; emit product.
  - IDLE, accepted beat, mode=1, last=1 -> stay IDLE; emit product (single-beat burst).
  - IDLE, accepted beat, mode=1, last=0 -> ACC; accumulator = product; no output.
  - ACC, accepted beat, last=0 -> stay ACC; accumulator += product; no output.
  - ACC, accepted beat, last=1 -> IDLE; emit accumulator + product; clear accumulator.
  - In ACC, i_mode is ignored; the burst stays accumulate until i_last.
- Latency: result for the beat accepted at cycle t (or the closing beat) has dv=1 at t+p_lat when there are no stalls. Beats that do not emit a result produce no dv.
- Throughput: one beat per cycle when not stalled; back-to-back bursts are allowed with no bubble.
- Overflow: any carry out of p_acc_w during a burst sets that lane's sticky flag. The flag is presented on o_ovf with the emitted result, then cleared. Without the saturate feature, the sum wraps modulo 2^p_acc_w.
- dv drops the cycle after a handshake (dv & i_ready) unless a new result is ready.

Optional Feature:
- Macro: COMP_MAC_SATURATE_EN.
- Defined: on overflow, the lane accumulator clamps to all-ones and stays clamped until the burst ends; o_ovf is still reported.
- Undefined: the lane accumulator wraps modulo 2^p_acc_w; o_ovf is reported.

Decomposition:
- Shared package/include comp_mac_pkg:
  - state encodings ST_IDLE / ST_ACC
  - mode constants MODE_MUL=0, MODE_ACC=1
  - default width function for p_acc_w
- Sub-module comp_mac_lane, instantiated p_lanes times:
  - contains the p_lat multiplier pipeline, accumulator, sticky overflow and saturation logic
  - FSM, handshake and stall generation stay in the top level.

Test Plan (p_size=4, p_lanes=2, p_acc_w=12, p_lat=2):
- Reset: hold rst 3 cycles with i_valid=1 -> dv=0, o_param=0, o_ready=0 throughout; o_ready=1 the first cycle after release with ena=1.
- Multiply: lane0 15*15, lane1 3*4, mode=0, accepted at t -> dv=1 at t+2; lane0=225, lane1=12; o_ovf=00.
- Accumulate: lane0 beats 2*3, 4*5, 1*1 with last on the third -> exactly one dv, lane0=27; no dv for beats 1-2.
- Overflow: 20 beats of 15*15 on lane0, last on the 20th -> 404 with o_ovf[0]=1; with COMP_MAC_SATURATE_EN, 4095 with o_ovf[0]=1.
- Backpressure: i_ready=0 for 3 cycles while dv=1 -> o_ready=0, o_param stable; after release, every result arrives in order, none dropped.
- Reset mid-burst: rst pulse after 2 accumulate beats -> dv=0; next burst 1*1 with last gives 1.
